// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer between PC/imem and decode
//
// Owns the PC, issues one instruction-memory request at a time
// (req/gnt/rvalid) and holds each fetched word in an output register until
// decode accepts it (valid/ready). Handles fetch enable, redirects and
// discarding of stale in-flight responses.
//
// Optional feature macro: FETCH_CTRL_PERF_EN (adds perf_fetched/perf_stall).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   en                  fetch enable; 0 stops new requests
//   redirect_valid/pc   one-cycle redirect pulse and target (bits [1:0] ignored)
//   imem_req/addr       request and word index (pc[ADDR_W+1:2]) to imem
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   response valid and instruction word
//   inst_valid/ready    output handshake towards decode
//   inst_pc/inst_data   PC and word of the held instruction
//   busy                high in REQ, WAIT or HOLD
//   perf_fetched/stall  (FETCH_CTRL_PERF_EN only) saturating counters

module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 5,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   inst_data,
  output logic              busy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic            req_q, valid_q, busy_q;

  // Low target bits are forced to zero, so they never reach any logic.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          // A redirect in the grant cycle makes the granted word stale.
          drop_d  = redirect_valid;
        end else if (!en && !redirect_valid) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = (en || redirect_valid) ? S_REQ : S_IDLE;
          end else begin
            inst_data_d = imem_rdata;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + XLEN'(4);
            state_d     = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect kills the held word even if decode is ready.
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
          state_d = en ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
      req_q       <= (state_d == S_REQ);
      valid_q     <= (state_d == S_HOLD);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q[ADDR_W+1:2];
  assign inst_valid = valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst_data  = inst_data_q;
  assign busy       = busy_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (valid_q && inst_ready && !redirect_valid && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((state_q == S_HOLD) && !inst_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard testbench for fetch_ctrl

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        busy;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // Reference model: architectural next-fetch PC and the single outstanding
  // memory transaction as seen from the memory side.
  logic [31:0] model_pc   = 32'h0;
  logic [31:0] granted_pc = 32'h0;
  bit          outstanding = 1'b0;
  bit          killed      = 1'b0;
  int          wait_cnt    = 0;
  int          cyc         = 0;
  int          last_gnt    = -1;
  bit          cadence_chk = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0043;
      1:       return 32'h0000_007C;
      2:       return 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  // One clock of stimulus: acts as instruction memory and as the redirect /
  // decode source, and updates the reference model for this cycle's inputs.
  task automatic drive_cycle(input int p_redir, input int p_gnt, input int p_ready,
                             input int p_en, input int max_wait);
    bit r;
    @(posedge clk);
    #1;
    cyc++;
    en             = ($urandom_range(0, 99) < p_en);
    inst_ready     = ($urandom_range(0, 99) < p_ready);
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    r = ($urandom_range(0, 99) < p_redir);
    if (r) begin
      redirect_valid = 1'b1;
      redirect_pc    = pick_target();
    end
    if (outstanding) begin
      check_eq("one_outstanding", {31'b0, imem_req}, 32'd0);
      wait_cnt--;
      if (wait_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem[granted_pc[6:2]];
        if (!killed && !r) begin
          sb_q.push_back('{pc: granted_pc, data: mem[granted_pc[6:2]]});
          model_pc = granted_pc + 32'd4;
        end
        outstanding = 1'b0;
      end else if (r) begin
        killed = 1'b1;
      end
    end else if (imem_req && ($urandom_range(0, 99) < p_gnt)) begin
      imem_gnt = 1'b1;
      check_eq("gnt_addr", {27'b0, imem_addr}, {27'b0, model_pc[6:2]});
      if (cadence_chk && last_gnt >= 0)
        check_eq("gnt_cadence", cyc - last_gnt, 32'd3);
      last_gnt    = cyc;
      granted_pc  = model_pc;
      outstanding = 1'b1;
      killed      = r;
      wait_cnt    = $urandom_range(1, max_wait);
    end else if ($urandom_range(0, 99) < 5) begin
      imem_rvalid = 1'b1;  // spurious response outside WAIT must be ignored
    end
    if (r) model_pc = {redirect_pc[31:2], 2'b00};
  endtask

  // Monitor: pops the scoreboard whenever a new instruction is presented and
  // checks hold/fall behaviour of the output register.
  initial begin
    bit          pv = 1'b0;
    bit          pready = 1'b0;
    bit          predir = 1'b0;
    logic [31:0] pdata = '0;
    logic [31:0] ppc = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        check_eq("reset_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("reset_req", {31'b0, imem_req}, 32'd0);
        pv = 1'b0;
        continue;
      end
      if (pv) begin
        if (pready || predir) begin
          check_eq("valid_fall", {31'b0, inst_valid}, 32'd0);
        end else begin
          check_eq("hold_valid", {31'b0, inst_valid}, 32'd1);
          check_eq("hold_data", inst_data, pdata);
          check_eq("hold_pc", inst_pc, ppc);
          check_eq("hold_no_req", {31'b0, imem_req}, 32'd0);
        end
      end else if (inst_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_inst", inst_pc, 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          check_eq("inst_pc", inst_pc, e.pc);
          check_eq("inst_data", inst_data, e.data);
          n_deliv++;
        end
      end
      pv     = inst_valid;
      pready = inst_ready;
      predir = redirect_valid;
      pdata  = inst_data;
      ppc    = inst_pc;
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    rst            = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr", {27'b0, imem_addr}, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;

    // Streaming with immediate grant, 1-cycle response, always-ready decode.
    cadence_chk = 1'b1;
    repeat (30) drive_cycle(0, 100, 100, 100, 1);
    cadence_chk = 1'b0;

    // Decode backpressure.
    repeat (200) drive_cycle(0, 100, 15, 100, 3);

    // Random mix of redirects, grant delays, enable gating and backpressure.
    repeat (3000) drive_cycle(8, 60, 60, 85, 3);

    // Reset while a response is outstanding; responses during and after reset.
    guard = 0;
    while (!outstanding && guard < 200) begin
      drive_cycle(0, 100, 100, 100, 3);
      guard++;
    end
    check_eq("found_outstanding", {31'b0, outstanding}, 32'd1);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hBAD0_BAD0;
    sb_q.delete();
    outstanding = 1'b0;
    killed      = 1'b0;
    model_pc    = 32'h0;
    @(posedge clk);
    #1;
    check_eq("midrst_addr", {27'b0, imem_addr}, 32'd0);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    rst         = 1'b1;
    en          = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD1_BAD1;

    repeat (1500) drive_cycle(8, 70, 70, 90, 3);

    // Drain: everything granted must eventually be delivered.
    guard = 0;
    while ((sb_q.size() != 0 || outstanding) && guard < 500) begin
      drive_cycle(0, 100, 100, 100, 3);
      guard++;
    end
    repeat (4) drive_cycle(0, 100, 100, 0, 3);
    check_eq("drain_empty", sb_q.size(), 32'd0);
    check_eq("delivered_enough", {31'b0, (n_deliv >= 50)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
